// File: rtl/frame_ones_accumulator.sv
// rtl/frame_ones_accumulator.sv - per-frame ones-count accumulator with valid/ready result port
module frame_ones_accumulator #(
    parameter int MAX_BYTES = 16,
    parameter int SUM_W     = 8,
    parameter int LEN_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       data_in,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic [SUM_W-1:0] thresh,
    output logic [SUM_W-1:0] data_out,
    output logic [LEN_W-1:0] byte_cnt,
    output logic             above_thresh,
    output logic             err_len,
    output logic             err_cnt,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SUM_WX = SUM_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SUM_W-1:0]  acc;
    logic [LEN_W-1:0]  cnt;
    logic              errc;

    logic [SUM_W-1:0]  acc_base;
    logic [SUM_W:0]    sum_wide;
    logic [SUM_W-1:0]  sum_sat;
    logic [LEN_W-1:0]  cnt_nxt;
    logic              errc_nxt;
    logic              beat_acc;
    logic              force_close;
    logic              frame_close;

    // The first beat of a frame starts from zero rather than the stale accumulator.
    always_comb begin
        acc_base    = (state == IDLE) ? '0 : acc;
        sum_wide    = {1'b0, acc_base} + SUM_WX'(data_in);
        sum_sat     = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
        cnt_nxt     = (state == IDLE) ? LEN_W'(1) : cnt + LEN_W'(1);
        errc_nxt    = ((state == IDLE) ? 1'b0 : errc) | (data_in > 4'd8);
        beat_acc    = in_valid && in_ready;
        force_close = (state == ACCUM) && !in_last && (cnt_nxt == LEN_W'(MAX_BYTES));
        frame_close = beat_acc && (in_last || force_close);
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                in_ready = !rst;
                if (beat_acc) begin
                    state_nxt = frame_close ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            errc         <= 1'b0;
            data_out     <= '0;
            byte_cnt     <= '0;
            above_thresh <= 1'b0;
            err_len      <= 1'b0;
            err_cnt      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (beat_acc) begin
                acc  <= sum_sat;
                cnt  <= cnt_nxt;
                errc <= errc_nxt;
            end
            // Result registers load only at frame close and then hold through HOLD.
            if (frame_close) begin
                data_out     <= sum_sat;
                byte_cnt     <= cnt_nxt;
                above_thresh <= (sum_sat >= thresh);
                err_len      <= force_close;
                err_cnt      <= errc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_frame_ones_accumulator.sv
// tb/tb_frame_ones_accumulator.sv - directed self-checking bench for frame_ones_accumulator
module tb_frame_ones_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] data_in;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] thresh;
    logic [7:0] data_out;
    logic [7:0] byte_cnt;
    logic       above_thresh;
    logic       err_len;
    logic       err_cnt;
    logic       out_valid;
    logic       out_ready;

    logic       in_ready2;
    logic [6:0] thresh2;
    logic [6:0] data_out2;
    logic [7:0] byte_cnt2;
    logic       above_thresh2;
    logic       err_len2;
    logic       err_cnt2;
    logic       out_valid2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign thresh2 = thresh[6:0];

    frame_ones_accumulator #(.MAX_BYTES(16), .SUM_W(8), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .thresh(thresh), .data_out(data_out), .byte_cnt(byte_cnt),
        .above_thresh(above_thresh), .err_len(err_len), .err_cnt(err_cnt),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    // Narrow-accumulator instance sharing the same stimulus to expose saturation.
    frame_ones_accumulator #(.MAX_BYTES(16), .SUM_W(7), .LEN_W(8)) dut_sat (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready2), .thresh(thresh2), .data_out(data_out2), .byte_cnt(byte_cnt2),
        .above_thresh(above_thresh2), .err_len(err_len2), .err_cnt(err_cnt2),
        .out_valid(out_valid2), .out_ready(out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int d, input logic last);
        in_valid = 1'b1;
        data_in  = 4'(d);
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        data_in  = 4'd0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; data_in = 4'd0; in_valid = 1'b0; in_last = 1'b0;
        thresh = 8'd0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_byte_cnt", int'(byte_cnt), 0);
        check("rst_flags", int'({above_thresh, err_len, err_cnt}), 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", int'(in_ready), 1);

        // Single-byte frame
        thresh = 8'd8;
        send(8, 1'b1);
        check("t1_out_valid", int'(out_valid), 1);
        check("t1_data_out", int'(data_out), 8);
        check("t1_byte_cnt", int'(byte_cnt), 1);
        check("t1_err_len", int'(err_len), 0);
        check("t1_above", int'(above_thresh), 1);
        check("t1_in_ready", int'(in_ready), 0);
        pop();
        check("t1_idle_valid", int'(out_valid), 0);
        check("t1_idle_ready", int'(in_ready), 1);

        // Gapped frame 3,0,5,8 with thresh 16
        thresh = 8'd16;
        send(3, 1'b0);
        tick();
        send(0, 1'b0);
        tick();
        tick();
        check("t2_no_early_valid", int'(out_valid), 0);
        send(5, 1'b0);
        tick();
        thresh = 8'd16;
        send(8, 1'b1);
        check("t2_out_valid", int'(out_valid), 1);
        check("t2_data_out", int'(data_out), 16);
        check("t2_byte_cnt", int'(byte_cnt), 4);
        check("t2_above", int'(above_thresh), 1);
        check("t2_err", int'({err_len, err_cnt}), 0);

        // Backpressure: outputs frozen, a beat offered during HOLD must be ignored
        thresh   = 8'd200;
        in_valid = 1'b1; data_in = 4'd7; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_data_out", int'(data_out), 16);
            check("bp_byte_cnt", int'(byte_cnt), 4);
            check("bp_above", int'(above_thresh), 1);
        end
        in_valid = 1'b0; in_last = 1'b0; data_in = 4'd0;
        pop();
        check("bp_idle_valid", int'(out_valid), 0);
        check("bp_idle_ready", int'(in_ready), 1);
        check("bp_result_kept", int'(data_out), 16);

        // Length overflow: 16 beats of 8, no in_last
        thresh = 8'd200;
        for (int i = 0; i < 16; i++) begin
            check("ovf_no_early_valid", int'(out_valid), 0);
            send(8, 1'b0);
        end
        check("ovf_out_valid", int'(out_valid), 1);
        check("ovf_data_out", int'(data_out), 128);
        check("ovf_byte_cnt", int'(byte_cnt), 16);
        check("ovf_err_len", int'(err_len), 1);
        check("ovf_above", int'(above_thresh), 0);
        check("ovf_sat7_data_out", int'(data_out2), 127);
        pop();
        send(1, 1'b1);
        check("ovf_next_valid", int'(out_valid), 1);
        check("ovf_next_byte_cnt", int'(byte_cnt), 1);
        check("ovf_next_data_out", int'(data_out), 1);
        check("ovf_next_err_len", int'(err_len), 0);
        pop();

        // Illegal counts, in_last on byte MAX_BYTES
        thresh = 8'd240;
        for (int i = 0; i < 15; i++) send(15, 1'b0);
        send(15, 1'b1);
        check("ill_out_valid", int'(out_valid), 1);
        check("ill_err_cnt", int'(err_cnt), 1);
        check("ill_data_out", int'(data_out), 240);
        check("ill_byte_cnt", int'(byte_cnt), 16);
        check("ill_err_len", int'(err_len), 0);
        check("ill_above", int'(above_thresh), 1);
        check("ill_sat7_data_out", int'(data_out2), 127);
        check("ill_sat7_err_cnt", int'(err_cnt2), 1);
        pop();

        // err_cnt must clear on the next clean frame
        send(2, 1'b0);
        send(2, 1'b1);
        check("clr_err_cnt", int'(err_cnt), 0);
        check("clr_data_out", int'(data_out), 4);
        pop();

        // Reset mid-frame
        thresh = 8'd1;
        send(4, 1'b0);
        send(4, 1'b0);
        rst = 1'b1;
        tick();
        check("mr_in_ready", int'(in_ready), 0);
        check("mr_data_out", int'(data_out), 0);
        rst = 1'b0;
        #1;
        check("mr_out_valid", int'(out_valid), 0);
        tick();
        check("mr_no_pulse", int'(out_valid), 0);
        send(2, 1'b1);
        check("mr_out_valid_new", int'(out_valid), 1);
        check("mr_data_out_new", int'(data_out), 2);
        check("mr_byte_cnt_new", int'(byte_cnt), 1);
        check("mr_err_new", int'({err_len, err_cnt}), 0);
        pop();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
